minibus_router: RTL and testbench
=================================

// Module: minibus_router
// PURPOSE
//  Registered, handshaked address router between one minibus master and SLAVE_COUNT slaves.
//  Decodes each request against per-slave [start,end) windows, selects one slave and waits for its response.
//  Unmapped addresses and optional timeouts return an error response; one transaction is outstanding at a time.
//  Sits between the core's bus master port and the peripheral/memory slaves.
// PARAMETERS
//  SLAVE_COUNT    4             number of slave ports (>=1)
//  ADDR_W         32            address width
//  DATA_W         32            data width (multiple of 8)
//  TIMEOUT_CYCLES 256           ACCESS cycles before error (MINIBUS_ROUTER_TIMEOUT_EN only, >=2)
//  ERR_DATA       32'hDEAD_BEEF rdata returned on any error (zero-extended/truncated to DATA_W)
// PORTS
//  clk          in  1                  clock, all logic on rising edge
//  rst          in  1                  synchronous active-high reset
//  m_req_valid  in  1                  master request valid
//  m_req_ready  out 1                  router can accept request
//  m_req_addr   in  ADDR_W             request address
//  m_req_wen    in  1                  1=write, 0=read
//  m_req_wdata  in  DATA_W             write data
//  m_req_wstrb  in  DATA_W/8           byte strobes
//  m_res_valid  out 1                  response valid, single-cycle pulse
//  m_res_rdata  out DATA_W             read data / ERR_DATA
//  m_res_err    out 1                  error flag
//  s_sel        out SLAVE_COUNT        one-hot slave select
//  s_req_addr/_wen/_wdata/_wstrb out   latched request, broadcast to all slaves
//  s_res_valid  in  SLAVE_COUNT        per-slave response valid
//  s_res_rdata  in  SLAVE_COUNT*DATA_W per-slave read data, slave i at [i*DATA_W +: DATA_W]
//  s_res_err    in  SLAVE_COUNT        per-slave error
//  map_start    in  SLAVE_COUNT*ADDR_W window start (inclusive), static during operation
//  map_end      in  SLAVE_COUNT*ADDR_W window end (exclusive); start>=end means window disabled
// BEHAVIOUR
//  Reset: state IDLE; m_req_ready=1, m_res_valid=0, m_res_err=0, m_res_rdata=0, s_sel=0, s_req_* =0, counter=0.
//  FSM IDLE -> ACCESS | RESP; ACCESS -> RESP; RESP -> IDLE. m_req_ready=1 only in IDLE.
//  IDLE: on m_req_valid, latch request into s_req_*; decode unsigned start<=addr<end, lowest index wins overlap.
//    hit i: s_sel<=1<<i, counter<=0, -> ACCESS.  miss: s_sel stays 0, rdata<=ERR_DATA, err<=1, -> RESP.
//  ACCESS: s_sel and s_req_* held stable; counter++ per cycle.
//    s_res_valid[i] (selected i): rdata<=s_res_rdata[i], err<=s_res_err[i], s_sel<=0, -> RESP.
//    s_res_valid of unselected slaves ignored in all states.
//  RESP: m_res_valid=1 exactly one cycle with rdata/err; -> IDLE. No backpressure on response.
//  Latency: miss = response 1 cycle after accept; hit with same-cycle slave reply = 2 cycles after accept.
//  Response and timeout in same cycle: response wins, err from slave.
//  rst mid-transaction: immediate return to IDLE, s_sel cleared, no m_res_valid generated.
//  rdata/err hold last value outside RESP (don't-care for master).
// CONFIGURATION
//  MINIBUS_ROUTER_TIMEOUT_EN defined: in ACCESS, when counter==TIMEOUT_CYCLES-1 and no response,
//    s_sel<=0, rdata<=ERR_DATA, err<=1, -> RESP. A late slave response afterwards is ignored.
//  Undefined: no counter logic; ACCESS waits indefinitely; TIMEOUT_CYCLES unused.
// STRUCTURE
//  minibus_pkg: minibus_router_state_e {IDLE,ACCESS,RESP}, MINIBUS_ERR_DATA default constant.
//  Sub-module minibus_addr_match: combinational, inputs addr + map_start/map_end,
//    outputs one-hot hit[SLAVE_COUNT] (lowest index only) and miss; instantiated once.
// TESTING
//  1 map s0=[0x0,0x1000) s1=[0x1000,0x2000); read 0x1004, s1 replies rdata=0x12345678 next cycle
//    -> s_sel=4'b0010 for 1 cycle, m_res_valid pulse 2 cycles after accept, rdata=0x12345678, err=0.
//  2 read 0x9000 (unmapped) -> s_sel stays 0, m_res_valid 1 cycle after accept, rdata=0xDEADBEEF, err=1.
//  3 overlap s0=[0,0x2000) s1=[0x1000,0x3000); write 0x1800 wdata=0xA5A5A5A5 wstrb=4'hF
//    -> only s0 selected, s_req_wdata=0xA5A5A5A5; s1 s_res_valid pulse ignored.
//  4 TIMEOUT_EN, TIMEOUT_CYCLES=8, slave silent -> err=1, rdata=0xDEADBEEF, s_sel drops after 8 ACCESS cycles;
//    slave reply 2 cycles later ignored; reply on cycle 8 itself -> slave data, err=0.
//  5 assert rst during ACCESS -> next cycle IDLE, s_sel=0, m_req_ready=1, no m_res_valid ever.
//  6 back-to-back: m_req_valid held high over 3 hits -> ready low during ACCESS/RESP, 3 responses, in order.

Source files
------------

// File: rtl/minibus_pkg.sv
// -----------------------------------------------------------------------------
// minibus_pkg
// Shared types and constants for the minibus router.
//   minibus_router_state_e : router FSM states (IDLE, ACCESS, RESP)
//   MINIBUS_ERR_DATA       : default read data returned on any error response
// -----------------------------------------------------------------------------
package minibus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } minibus_router_state_e;

   localparam logic [31:0] MINIBUS_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/minibus_addr_match.sv
// -----------------------------------------------------------------------------
// minibus_addr_match
// Combinational address decoder. Each slave owns the window [start, end);
// a window with start >= end is disabled. When windows overlap, the lowest
// slave index wins, so hit is always zero- or one-hot.
// Ports:
//   addr       in  ADDR_W              address to decode
//   map_start  in  SLAVE_COUNT*ADDR_W  window starts (inclusive), slave i at [i*ADDR_W +: ADDR_W]
//   map_end    in  SLAVE_COUNT*ADDR_W  window ends (exclusive)
//   hit        out SLAVE_COUNT         one-hot winning slave
//   miss       out 1                   no enabled window contains addr
// -----------------------------------------------------------------------------
module minibus_addr_match #(
   parameter int SLAVE_COUNT = 4,
   parameter int ADDR_W      = 32
) (
   input  logic [ADDR_W-1:0]             addr,
   input  logic [SLAVE_COUNT*ADDR_W-1:0] map_start,
   input  logic [SLAVE_COUNT*ADDR_W-1:0] map_end,
   output logic [SLAVE_COUNT-1:0]        hit,
   output logic                          miss
);

   logic [SLAVE_COUNT-1:0] in_win;

   for (genvar gi = 0; gi < SLAVE_COUNT; gi++) begin : g_win
      logic [ADDR_W-1:0] w_start;
      logic [ADDR_W-1:0] w_end;
      assign w_start    = map_start[gi*ADDR_W +: ADDR_W];
      assign w_end      = map_end[gi*ADDR_W +: ADDR_W];
      // start < end also rejects disabled windows, since no addr satisfies both bounds then
      assign in_win[gi] = (w_start < w_end) && (addr >= w_start) && (addr < w_end);
   end

   // Priority pick: keep only the lowest matching index.
   always_comb begin
      logic found;
      hit   = '0;
      found = 1'b0;
      for (int i = 0; i < SLAVE_COUNT; i++) begin
         if (in_win[i] && !found) begin
            hit[i] = 1'b1;
            found  = 1'b1;
         end
      end
   end

   assign miss = ~|in_win;

endmodule

// File: rtl/minibus_router.sv
// -----------------------------------------------------------------------------
// minibus_router
// Registered, handshaked router from one minibus master to SLAVE_COUNT slaves.
// One transaction outstanding at a time: IDLE accepts and decodes, ACCESS
// waits for the selected slave, RESP presents a single-cycle response.
// Unmapped addresses answer with ERR_DATA / err=1 directly from IDLE.
// Optional feature macro: MINIBUS_ROUTER_TIMEOUT_EN -- when defined, an
// ACCESS lasting TIMEOUT_CYCLES cycles without a reply ends in an error
// response; when undefined, ACCESS waits for the slave indefinitely.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   m_req_valid/ready/addr/wen/wdata/wstrb   master request channel
//   m_res_valid/rdata/err          master response (one-cycle pulse)
//   s_sel                          one-hot slave select
//   s_req_addr/wen/wdata/wstrb     latched request, broadcast to all slaves
//   s_res_valid/rdata/err          per-slave response inputs
//   map_start/map_end              per-slave [start,end) windows (static)
// -----------------------------------------------------------------------------
module minibus_router
   import minibus_pkg::*;
#(
   parameter int          SLAVE_COUNT    = 4,
   parameter int          ADDR_W         = 32,
   parameter int          DATA_W         = 32,
   parameter int          TIMEOUT_CYCLES = 256,
   parameter logic [31:0] ERR_DATA       = MINIBUS_ERR_DATA
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          m_req_valid,
   output logic                          m_req_ready,
   input  logic [ADDR_W-1:0]             m_req_addr,
   input  logic                          m_req_wen,
   input  logic [DATA_W-1:0]             m_req_wdata,
   input  logic [DATA_W/8-1:0]           m_req_wstrb,
   output logic                          m_res_valid,
   output logic [DATA_W-1:0]             m_res_rdata,
   output logic                          m_res_err,
   output logic [SLAVE_COUNT-1:0]        s_sel,
   output logic [ADDR_W-1:0]             s_req_addr,
   output logic                          s_req_wen,
   output logic [DATA_W-1:0]             s_req_wdata,
   output logic [DATA_W/8-1:0]           s_req_wstrb,
   input  logic [SLAVE_COUNT-1:0]        s_res_valid,
   input  logic [SLAVE_COUNT*DATA_W-1:0] s_res_rdata,
   input  logic [SLAVE_COUNT-1:0]        s_res_err,
   input  logic [SLAVE_COUNT*ADDR_W-1:0] map_start,
   input  logic [SLAVE_COUNT*ADDR_W-1:0] map_end
);

   localparam int                STRB_W   = DATA_W / 8;
   localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(ERR_DATA);

   minibus_router_state_e   state_q, state_d;
   logic                    m_req_ready_q, m_req_ready_d;
   logic                    m_res_valid_q, m_res_valid_d;
   logic [DATA_W-1:0]       m_res_rdata_q, m_res_rdata_d;
   logic                    m_res_err_q, m_res_err_d;
   logic [SLAVE_COUNT-1:0]  s_sel_q, s_sel_d;
   logic [ADDR_W-1:0]       s_req_addr_q, s_req_addr_d;
   logic                    s_req_wen_q, s_req_wen_d;
   logic [DATA_W-1:0]       s_req_wdata_q, s_req_wdata_d;
   logic [STRB_W-1:0]       s_req_wstrb_q, s_req_wstrb_d;

`ifdef MINIBUS_ROUTER_TIMEOUT_EN
   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0]            cnt_q, cnt_d;
`endif

   logic [SLAVE_COUNT-1:0] dec_hit;
   logic                   dec_miss;

   minibus_addr_match #(
      .SLAVE_COUNT (SLAVE_COUNT),
      .ADDR_W      (ADDR_W)
   ) u_addr_match (
      .addr      (m_req_addr),
      .map_start (map_start),
      .map_end   (map_end),
      .hit       (dec_hit),
      .miss      (dec_miss)
   );

   // Response from the selected slave only; unselected slaves are masked off
   // by s_sel_q, which is all-zero outside ACCESS.
   logic [DATA_W-1:0] slot_rdata [SLAVE_COUNT];
   logic [DATA_W-1:0] sel_rdata;
   logic              sel_valid;
   logic              sel_err;

   for (genvar gi = 0; gi < SLAVE_COUNT; gi++) begin : g_slot
      assign slot_rdata[gi] = s_sel_q[gi] ? s_res_rdata[gi*DATA_W +: DATA_W] : '0;
   end

   always_comb begin
      sel_rdata = '0;
      for (int i = 0; i < SLAVE_COUNT; i++) begin
         sel_rdata = sel_rdata | slot_rdata[i];
      end
   end

   assign sel_valid = |(s_res_valid & s_sel_q);
   assign sel_err   = |(s_res_err & s_sel_q);

   always_comb begin
      state_d       = state_q;
      m_req_ready_d = m_req_ready_q;
      m_res_valid_d = 1'b0;
      m_res_rdata_d = m_res_rdata_q;
      m_res_err_d   = m_res_err_q;
      s_sel_d       = s_sel_q;
      s_req_addr_d  = s_req_addr_q;
      s_req_wen_d   = s_req_wen_q;
      s_req_wdata_d = s_req_wdata_q;
      s_req_wstrb_d = s_req_wstrb_q;
`ifdef MINIBUS_ROUTER_TIMEOUT_EN
      cnt_d         = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (m_req_valid) begin
               s_req_addr_d  = m_req_addr;
               s_req_wen_d   = m_req_wen;
               s_req_wdata_d = m_req_wdata;
               s_req_wstrb_d = m_req_wstrb;
               m_req_ready_d = 1'b0;
               if (dec_miss) begin
                  m_res_rdata_d = ERR_WORD;
                  m_res_err_d   = 1'b1;
                  m_res_valid_d = 1'b1;
                  state_d       = RESP;
               end else begin
                  s_sel_d = dec_hit;
`ifdef MINIBUS_ROUTER_TIMEOUT_EN
                  cnt_d   = '0;
`endif
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            // A reply in the final timeout cycle still wins over the timeout.
            if (sel_valid) begin
               m_res_rdata_d = sel_rdata;
               m_res_err_d   = sel_err;
               m_res_valid_d = 1'b1;
               s_sel_d       = '0;
               state_d       = RESP;
            end
`ifdef MINIBUS_ROUTER_TIMEOUT_EN
            else if (cnt_q == CNT_LAST) begin
               m_res_rdata_d = ERR_WORD;
               m_res_err_d   = 1'b1;
               m_res_valid_d = 1'b1;
               s_sel_d       = '0;
               state_d       = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         RESP: begin
            m_req_ready_d = 1'b1;
            state_d       = IDLE;
         end
         default: begin
            m_req_ready_d = 1'b1;
            s_sel_d       = '0;
            state_d       = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         m_req_ready_q <= 1'b1;
         m_res_valid_q <= 1'b0;
         m_res_rdata_q <= '0;
         m_res_err_q   <= 1'b0;
         s_sel_q       <= '0;
         s_req_addr_q  <= '0;
         s_req_wen_q   <= 1'b0;
         s_req_wdata_q <= '0;
         s_req_wstrb_q <= '0;
`ifdef MINIBUS_ROUTER_TIMEOUT_EN
         cnt_q         <= '0;
`endif
      end else begin
         state_q       <= state_d;
         m_req_ready_q <= m_req_ready_d;
         m_res_valid_q <= m_res_valid_d;
         m_res_rdata_q <= m_res_rdata_d;
         m_res_err_q   <= m_res_err_d;
         s_sel_q       <= s_sel_d;
         s_req_addr_q  <= s_req_addr_d;
         s_req_wen_q   <= s_req_wen_d;
         s_req_wdata_q <= s_req_wdata_d;
         s_req_wstrb_q <= s_req_wstrb_d;
`ifdef MINIBUS_ROUTER_TIMEOUT_EN
         cnt_q         <= cnt_d;
`endif
      end
   end

   assign m_req_ready = m_req_ready_q;
   assign m_res_valid = m_res_valid_q;
   assign m_res_rdata = m_res_rdata_q;
   assign m_res_err   = m_res_err_q;
   assign s_sel       = s_sel_q;
   assign s_req_addr  = s_req_addr_q;
   assign s_req_wen   = s_req_wen_q;
   assign s_req_wdata = s_req_wdata_q;
   assign s_req_wstrb = s_req_wstrb_q;

endmodule

// File: tb/tb_minibus_router.sv
// -----------------------------------------------------------------------------
// tb_minibus_router
// Directed bench for minibus_router. The driver pushes the expected response
// (rdata, err, cycle of the m_res_valid pulse) into a queue when it issues a
// request; a monitor forked alongside pops and compares on every response.
// Request-side and select-side signals are checked inline by the driver.
// Build with MINIBUS_ROUTER_TIMEOUT_EN defined to exercise the timeout path.
// -----------------------------------------------------------------------------
module tb_minibus_router;

   localparam int          N   = 4;
   localparam int          AW  = 32;
   localparam int          DW  = 32;
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;

   logic              clk = 1'b0;
   logic              rst;
   logic              m_req_valid;
   logic              m_req_ready;
   logic [AW-1:0]     m_req_addr;
   logic              m_req_wen;
   logic [DW-1:0]     m_req_wdata;
   logic [DW/8-1:0]   m_req_wstrb;
   logic              m_res_valid;
   logic [DW-1:0]     m_res_rdata;
   logic              m_res_err;
   logic [N-1:0]      s_sel;
   logic [AW-1:0]     s_req_addr;
   logic              s_req_wen;
   logic [DW-1:0]     s_req_wdata;
   logic [DW/8-1:0]   s_req_wstrb;
   logic [N-1:0]      s_res_valid;
   logic [N*DW-1:0]   s_res_rdata;
   logic [N-1:0]      s_res_err;
   logic [N*AW-1:0]   map_start;
   logic [N*AW-1:0]   map_end;

   // Slave side: either driven by hand, or an auto responder that answers
   // the selected slave in its first ACCESS cycle with 0x1000_0000 + addr.
   logic              auto_resp;
   logic [N-1:0]      man_valid;
   logic [N-1:0]      man_err;
   logic [N*DW-1:0]   man_rdata;
   logic [DW-1:0]     auto_word;

   assign auto_word   = 32'h1000_0000 + s_req_addr;
   assign s_res_valid = auto_resp ? s_sel : man_valid;
   assign s_res_err   = auto_resp ? '0 : man_err;
   assign s_res_rdata = auto_resp ? {N{auto_word}} : man_rdata;

   minibus_router #(
      .SLAVE_COUNT    (N),
      .ADDR_W         (AW),
      .DATA_W         (DW),
      .TIMEOUT_CYCLES (8),
      .ERR_DATA       (ERR)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .m_req_valid (m_req_valid),
      .m_req_ready (m_req_ready),
      .m_req_addr  (m_req_addr),
      .m_req_wen   (m_req_wen),
      .m_req_wdata (m_req_wdata),
      .m_req_wstrb (m_req_wstrb),
      .m_res_valid (m_res_valid),
      .m_res_rdata (m_res_rdata),
      .m_res_err   (m_res_err),
      .s_sel       (s_sel),
      .s_req_addr  (s_req_addr),
      .s_req_wen   (s_req_wen),
      .s_req_wdata (s_req_wdata),
      .s_req_wstrb (s_req_wstrb),
      .s_res_valid (s_res_valid),
      .s_res_rdata (s_res_rdata),
      .s_res_err   (s_res_err),
      .map_start   (map_start),
      .map_end     (map_end)
   );

   always #5 clk = ~clk;

   // cyc == number of rising edges seen so far (read on falling edges)
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      string       name;
      logic [31:0] rdata;
      logic        err;
      int          at_cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic set_map(input int i, input logic [31:0] s, input logic [31:0] e);
      map_start[i*AW +: AW] = s;
      map_end[i*AW +: AW]   = e;
   endtask

   task automatic map_a();
      set_map(0, 32'h0000_0000, 32'h0000_1000);
      set_map(1, 32'h0000_1000, 32'h0000_2000);
      set_map(2, 32'h0000_2000, 32'h0000_3000);
      set_map(3, 32'h0000_5000, 32'h0000_5000);   // disabled window
   endtask

   // One request. idx<0 means an expected miss. The selected slave replies
   // 'delay' cycles into ACCESS; spur>=0 pulses an unselected slave first.
   task automatic txn(input string nm, input logic [31:0] addr, input logic wen,
                      input logic [31:0] wdata, input logic [3:0] wstrb,
                      input int idx, input int delay,
                      input logic [31:0] rd, input logic er, input int spur);
      int   c;
      exp_t e;
      @(negedge clk);
      chk({nm, "_ready_idle"}, 64'(m_req_ready), 64'd1);
      m_req_valid = 1'b1;
      m_req_addr  = addr;
      m_req_wen   = wen;
      m_req_wdata = wdata;
      m_req_wstrb = wstrb;
      c = cyc;
      if (idx < 0) e = '{nm, ERR, 1'b1, c + 1};
      else         e = '{nm, rd, er, c + 2 + delay};
      exp_q.push_back(e);
      @(negedge clk);
      m_req_valid = 1'b0;
      chk({nm, "_ready_busy"}, 64'(m_req_ready), 64'd0);
      if (idx < 0) begin
         chk({nm, "_sel_miss"}, 64'(s_sel), 64'd0);
      end else begin
         chk({nm, "_sel"},   64'(s_sel), 64'(1 << idx));
         chk({nm, "_addr"},  64'(s_req_addr), 64'(addr));
         chk({nm, "_wen"},   64'(s_req_wen), 64'(wen));
         chk({nm, "_wdata"}, 64'(s_req_wdata), 64'(wdata));
         chk({nm, "_wstrb"}, 64'(s_req_wstrb), 64'(wstrb));
         for (int i = 0; i <= delay; i++) begin
            man_valid = '0;
            man_err   = '0;
            if (i > 0) chk({nm, "_sel_hold"}, 64'(s_sel), 64'(1 << idx));
            if (i == delay) begin
               man_valid[idx]            = 1'b1;
               man_rdata[idx*DW +: DW]   = rd;
               man_err[idx]              = er;
            end else if (i == 0 && spur >= 0) begin
               man_valid[spur]           = 1'b1;
               man_rdata[spur*DW +: DW]  = 32'hBAD0_0BAD;
               man_err[spur]             = 1'b1;
            end
            @(negedge clk);
         end
         man_valid = '0;
         man_err   = '0;
         chk({nm, "_sel_drop"}, 64'(s_sel), 64'd0);
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   logic [31:0] b2b_addr [3];
   int          b2b_idx  [3];
   int          c;

   initial begin
      rst         = 1'b1;
      m_req_valid = 1'b0;
      m_req_addr  = '0;
      m_req_wen   = 1'b0;
      m_req_wdata = '0;
      m_req_wstrb = '0;
      man_valid   = '0;
      man_err     = '0;
      man_rdata   = '0;
      auto_resp   = 1'b0;
      map_start   = '0;
      map_end     = '0;
      map_a();
      repeat (3) @(negedge clk);

      // reset state
      chk("rst_ready",  64'(m_req_ready), 64'd1);
      chk("rst_rvalid", 64'(m_res_valid), 64'd0);
      chk("rst_err",    64'(m_res_err), 64'd0);
      chk("rst_rdata",  64'(m_res_rdata), 64'd0);
      chk("rst_sel",    64'(s_sel), 64'd0);
      chk("rst_saddr",  64'(s_req_addr), 64'd0);
      chk("rst_swdata", 64'(s_req_wdata), 64'd0);
      rst = 1'b0;

      fork
         forever begin
            @(negedge clk);
            if (m_res_valid === 1'b1) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_resp actual=rdata %h err %b cycle %0d required=no response",
                           m_res_rdata, m_res_err, cyc);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  $display("RESP %-10s rdata=%h err=%b cycle=%0d", e.name, m_res_rdata, m_res_err, cyc);
                  chk({e.name, "_rdata"}, 64'(m_res_rdata), 64'(e.rdata));
                  chk({e.name, "_err"},   64'(m_res_err), 64'(e.err));
                  chk({e.name, "_cycle"}, 64'(cyc), 64'(e.at_cyc));
               end
            end
         end
      join_none

      // hits, including window edges and slave error passthrough
      txn("rd_s1",   32'h0000_1004, 1'b0, 32'h0, 4'h0, 1, 0, 32'h1234_5678, 1'b0, -1);
      txn("wr_s0",   32'h0000_0FFF, 1'b1, 32'h1122_3344, 4'h3, 0, 2, 32'hCAFE_F00D, 1'b1, -1);
      txn("rd_s1lo", 32'h0000_1000, 1'b0, 32'h0, 4'h0, 1, 1, 32'h0000_0001, 1'b0, -1);
      txn("rd_s2",   32'h0000_2FFC, 1'b0, 32'h0, 4'h0, 2, 1, 32'hFEDC_BA98, 1'b0, -1);

      // misses: unmapped, disabled window, exclusive end
      txn("miss_9k", 32'h0000_9000, 1'b0, 32'h0, 4'h0, -1, 0, 32'h0, 1'b0, -1);
      txn("miss_dis",32'h0000_5000, 1'b0, 32'h0, 4'h0, -1, 0, 32'h0, 1'b0, -1);
      txn("miss_end",32'h0000_3000, 1'b1, 32'h5555_AAAA, 4'hF, -1, 0, 32'h0, 1'b0, -1);

      // overlap: lowest index wins, unselected s1 pulse ignored
      set_map(0, 32'h0000_0000, 32'h0000_2000);
      set_map(1, 32'h0000_1000, 32'h0000_3000);
      txn("overlap", 32'h0000_1800, 1'b1, 32'hA5A5_A5A5, 4'hF, 0, 2, 32'h0000_0000, 1'b0, 1);
      map_a();

`ifdef MINIBUS_ROUTER_TIMEOUT_EN
      // silent slave: error after 8 ACCESS cycles, late reply ignored
      @(negedge clk);
      m_req_valid = 1'b1;
      m_req_addr  = 32'h0000_0100;
      m_req_wen   = 1'b0;
      c = cyc;
      exp_q.push_back('{"timeout", ERR, 1'b1, c + 9});
      @(negedge clk);
      m_req_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk("to_sel_hold", 64'(s_sel), 64'd1);
         @(negedge clk);
      end
      chk("to_sel_drop", 64'(s_sel), 64'd0);
      repeat (2) @(negedge clk);
      man_valid[0]       = 1'b1;
      man_rdata[0 +: DW] = 32'h7777_7777;
      @(negedge clk);
      man_valid = '0;
      @(negedge clk);
      // reply in the last ACCESS cycle beats the timeout
      txn("to_edge", 32'h0000_0100, 1'b0, 32'h0, 4'h0, 0, 7, 32'h600D_F00D, 1'b0, -1);
`else
      // no timeout logic: a long wait still ends with the slave's data
      txn("long_wait", 32'h0000_0100, 1'b0, 32'h0, 4'h0, 0, 20, 32'h600D_F00D, 1'b0, -1);
`endif

      // reset in ACCESS: back to IDLE, no response ever
      @(negedge clk);
      m_req_valid = 1'b1;
      m_req_addr  = 32'h0000_0200;
      m_req_wen   = 1'b0;
      @(negedge clk);
      m_req_valid = 1'b0;
      chk("rstmid_sel_before", 64'(s_sel), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid_sel",    64'(s_sel), 64'd0);
      chk("rstmid_ready",  64'(m_req_ready), 64'd1);
      chk("rstmid_rvalid", 64'(m_res_valid), 64'd0);
      rst = 1'b0;
      repeat (6) @(negedge clk);

      // back-to-back with m_req_valid held high
      b2b_addr = '{32'h0000_0004, 32'h0000_2ABC, 32'h0000_1FFC};
      b2b_idx  = '{0, 2, 1};
      auto_resp = 1'b1;
      @(negedge clk);
      m_req_valid = 1'b1;
      m_req_wen   = 1'b0;
      for (int k = 0; k < 3; k++) begin
         int w;
         w = 0;
         while (m_req_ready !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
         end
         chk("b2b_ready_idle", 64'(m_req_ready), 64'd1);
         m_req_addr = b2b_addr[k];
         exp_q.push_back('{"b2b", 32'h1000_0000 + b2b_addr[k], 1'b0, cyc + 2});
         @(negedge clk);
         if (k == 2) m_req_valid = 1'b0;
         chk("b2b_sel",          64'(s_sel), 64'(1 << b2b_idx[k]));
         chk("b2b_ready_access", 64'(m_req_ready), 64'd0);
         @(negedge clk);
         chk("b2b_ready_resp",   64'(m_req_ready), 64'd0);
      end
      m_req_valid = 1'b0;
      auto_resp   = 1'b0;

      repeat (4) @(negedge clk);
      chk("drain_pending", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
